// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

    // Register fields are held at this width inside the scoreboard. Narrower
    // register address widths are zero-extended on entry.
    localparam int SB_AW = 8;

    localparam int STG_EX = 0;
    localparam int STG_MA = 1;
    localparam int STG_WB = 2;

    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] rd;
        logic             regwrite;
        logic             memread;
        logic [SB_AW-1:0] rs1;
        logic [SB_AW-1:0] rs2;
        logic             rs1_used;
        logic             rs2_used;
    } sb_entry_t;

    // A producer whose result may be consumed: real, writing, and not x0.
    function automatic logic is_live(input sb_entry_t e);
        return e.valid & e.regwrite & (e.rd != '0);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise increment and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge CLK) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: shadow scoreboard of EX..WB, forwarding
// selects, load-use stall, branch flush and multi-cycle EX freeze.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW           = 5,
    parameter int DEPTH            = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int CNT_W            = 32,
    parameter int SEL_W            = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_busy,
    input  logic              ex_branch_taken,
    output logic [SEL_W-1:0]  fwd_sel_rs1,
    output logic [SEL_W-1:0]  fwd_sel_rs2,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic              hold_ex,
    output logic              bubble_ma,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    sb_entry_t e_q [DEPTH];
    sb_entry_t e_d [DEPTH];
    sb_entry_t id_entry;
    logic      hazard;

    assign id_entry = '{valid:    1'b1,
                        rd:       SB_AW'(id_rd),
                        regwrite: id_regwrite,
                        memread:  id_memread,
                        rs1:      SB_AW'(id_rs1),
                        rs2:      SB_AW'(id_rs2),
                        rs1_used: id_rs1_used,
                        rs2_used: id_rs2_used};

    // Forwarding selects: scan from the oldest stage down so the youngest
    // qualifying producer wins. Loads only forward once their data exists.
    always_comb begin
        fwd_sel_rs1 = SEL_W'(FWD_REGFILE);
        fwd_sel_rs2 = SEL_W'(FWD_REGFILE);
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (is_live(e_q[k]) && (!e_q[k].memread || k >= LOAD_READY_STAGE)) begin
                if (e_q[STG_EX].rs1_used && (e_q[k].rd == e_q[STG_EX].rs1))
                    fwd_sel_rs1 = SEL_W'(k);
                if (e_q[STG_EX].rs2_used && (e_q[k].rd == e_q[STG_EX].rs2))
                    fwd_sel_rs2 = SEL_W'(k);
            end
        end
    end

    // Load-use detection against loads too young to forward to the ID consumer.
    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < LOAD_READY_STAGE - 1; s++) begin
            if (is_live(e_q[s]) && e_q[s].memread &&
                ((id_rs1_used && (e_q[s].rd == id_entry.rs1)) ||
                 (id_rs2_used && (e_q[s].rd == id_entry.rs2))))
                hazard = 1'b1;
        end
        hazard = hazard & id_valid;
    end

    // Control outputs by priority: busy freeze, branch flush, load-use stall.
    always_comb begin
        stall_if    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        hold_ex     = 1'b0;
        bubble_ma   = 1'b0;
        if (ex_busy) begin
            hold_ex   = 1'b1;
            stall_if  = 1'b1;
            bubble_ma = 1'b1;
        end else if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (hazard) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    // Scoreboard next state: while busy EX holds and a bubble enters MA.
    always_comb begin
        for (int s = 0; s < DEPTH; s++) e_d[s] = e_q[s];
        if (ex_busy) begin
            e_d[1] = '0;
            for (int s = 2; s < DEPTH; s++) e_d[s] = e_q[s-1];
        end else begin
            for (int s = 1; s < DEPTH; s++) e_d[s] = e_q[s-1];
            e_d[STG_EX] = (id_valid && !bubble_ex) ? id_entry : '0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int s = 0; s < DEPTH; s++) e_q[s] <= '0;
        end else begin
            for (int s = 0; s < DEPTH; s++) e_q[s] <= e_d[s];
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .clear (!RESET),
        .inc   (stall_if),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .clear (!RESET),
        .inc   (flush_if_id),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit with 4-bit counters.
module tb_pipe_hazard_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int SEL_W  = 2;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_rs1_used, id_rs2_used, id_regwrite, id_memread;
    logic              ex_busy, ex_branch_taken;
    logic [SEL_W-1:0]  fwd_sel_rs1, fwd_sel_rs2;
    logic              stall_if, bubble_ex, flush_if_id, hold_ex, bubble_ma;
    logic [CNT_W-1:0]  stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pipe_hazard_unit #(.REG_AW(REG_AW), .DEPTH(3), .LOAD_READY_STAGE(2), .CNT_W(CNT_W)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .ex_busy         (ex_busy),
        .ex_branch_taken (ex_branch_taken),
        .fwd_sel_rs1     (fwd_sel_rs1),
        .fwd_sel_rs2     (fwd_sel_rs2),
        .stall_if        (stall_if),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id),
        .hold_ex         (hold_ex),
        .bubble_ma       (bubble_ma),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Control vector order: {stall_if, bubble_ex, flush_if_id, hold_ex, bubble_ma}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, stall_if, bubble_ex, flush_if_id, hold_ex, bubble_ma}, {27'd0, exp});
    endtask

    task automatic chk_fwd(input string tag, input logic [SEL_W-1:0] e1, input logic [SEL_W-1:0] e2);
        chk({tag, "_rs1"}, 32'(fwd_sel_rs1), 32'(e1));
        chk({tag, "_rs2"}, 32'(fwd_sel_rs2), 32'(e2));
    endtask

    task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2,
                          input logic u2, input int rd, input logic rw, input logic mr);
        id_valid    = v;
        id_rs1      = REG_AW'(rs1);
        id_rs1_used = u1;
        id_rs2      = REG_AW'(rs2);
        id_rs2_used = u2;
        id_rd       = REG_AW'(rd);
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic idle();
        set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        ex_busy = 1'b0;
        ex_branch_taken = 1'b0;
        idle();
        repeat (2) tick();
        RESET = 1'b1;
        #1;
        chk_ctl("reset_ctl", 5'b00000);
        chk_fwd("reset_fwd", 2'd0, 2'd0);
        chk("reset_stall_cnt", 32'(stall_count), 32'd0);
        chk("reset_flush_cnt", 32'(flush_count), 32'd0);

        // add x5,x1,x2 ; sub x6,x5,x3 ; or x11,x5,x6
        set_id(1, 1, 1, 2, 1, 5, 1, 0); #1; chk_ctl("alu_add_ctl", 5'b00000); tick();
        set_id(1, 5, 1, 3, 1, 6, 1, 0); #1; chk_ctl("alu_sub_ctl", 5'b00000); tick();
        set_id(1, 5, 1, 6, 1, 11, 1, 0); #1;
        chk_fwd("alu_sub_ex", 2'd1, 2'd0);
        chk_ctl("alu_or_ctl", 5'b00000);
        tick();
        idle(); #1;
        chk_fwd("alu_or_ex", 2'd2, 2'd1);
        chk("alu_stall_cnt", 32'(stall_count), 32'd0);
        repeat (4) tick();

        // lw x7,0(x1) ; add x8,x7,x2
        set_id(1, 1, 1, 0, 0, 7, 1, 1); #1; chk_ctl("lu_lw_ctl", 5'b00000); tick();
        set_id(1, 7, 1, 2, 1, 8, 1, 0); #1; chk_ctl("lu_stall_ctl", 5'b11000); tick();
        #1; chk_ctl("lu_after_ctl", 5'b00000); chk_fwd("lu_bubble_fwd", 2'd0, 2'd0); tick();
        idle(); #1;
        chk_fwd("lu_add_ex", 2'd2, 2'd0);
        chk("lu_stall_cnt", 32'(stall_count), 32'd1);
        repeat (4) tick();

        // addi x0,x1,4 ; add x9,x0,x0 ; consumer with unused rs2 = x9
        set_id(1, 1, 1, 0, 0, 0, 1, 0); tick();
        set_id(1, 0, 1, 0, 1, 9, 1, 0); #1; chk_ctl("x0_ctl", 5'b00000); tick();
        set_id(1, 3, 1, 9, 0, 12, 1, 0); #1; chk_fwd("x0_fwd", 2'd0, 2'd0); tick();
        idle(); #1;
        chk_fwd("unused_rs2_fwd", 2'd0, 2'd0);
        chk("x0_stall_cnt", 32'(stall_count), 32'd1);
        repeat (4) tick();

        // Branch taken while ID holds a load-use consumer
        set_id(1, 1, 1, 0, 0, 7, 1, 1); tick();
        set_id(1, 7, 1, 2, 1, 8, 1, 0);
        ex_branch_taken = 1'b1; #1;
        chk_ctl("br_ctl", 5'b01100);
        tick();
        ex_branch_taken = 1'b0; idle(); #1;
        chk_ctl("br_after_ctl", 5'b00000);
        chk("br_flush_cnt", 32'(flush_count), 32'd1);
        chk("br_stall_cnt", 32'(stall_count), 32'd1);
        repeat (4) tick();

        // div x13,x1,x2 busy for 3 cycles, then add x14,x13,x4
        set_id(1, 1, 1, 2, 1, 13, 1, 0); tick();
        set_id(1, 13, 1, 4, 1, 14, 1, 0);
        ex_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_branch_taken = (i == 1);
            #1;
            chk_ctl($sformatf("busy_ctl_%0d", i), 5'b10011);
            tick();
        end
        ex_busy = 1'b0; ex_branch_taken = 1'b0; #1;
        chk_ctl("busy_end_ctl", 5'b00000);
        chk("busy_stall_cnt", 32'(stall_count), 32'd4);
        chk("busy_flush_cnt", 32'(flush_count), 32'd1);
        tick();
        idle(); #1;
        chk_fwd("busy_dep_fwd", 2'd1, 2'd0);
        repeat (4) tick();

        // Saturation: 20 further stall cycles
        ex_busy = 1'b1;
        repeat (20) tick();
        ex_busy = 1'b0; #1;
        chk("sat_stall_cnt", 32'(stall_count), 32'd15);
        repeat (3) tick();

        // Reset in the middle of a load-use stall
        set_id(1, 1, 1, 0, 0, 7, 1, 1); tick();
        set_id(1, 7, 1, 2, 1, 8, 1, 0); #1;
        chk_ctl("rst_pre_ctl", 5'b11000);
        RESET = 1'b0;
        tick();
        RESET = 1'b1; #1;
        chk_ctl("rst_post_ctl", 5'b00000);
        chk_fwd("rst_post_fwd", 2'd0, 2'd0);
        chk("rst_stall_cnt", 32'(stall_count), 32'd0);
        chk("rst_flush_cnt", 32'(flush_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
